// File: rtl/risc_ctrl_pkg.sv
// Shared encodings for the multi-cycle RISC controller: states, opcodes, alu_op/pc_src codes.
// MCU_TRAP_EN (optional define) routes opcodes 1010/1110/1111 to TRAP instead of data-processing.
package risc_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_FAULT  = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  localparam logic [3:0] OP_LW    = 4'b0000;
  localparam logic [3:0] OP_SW    = 4'b0001;
  localparam logic [3:0] OP_DP_LO = 4'b0010;
  localparam logic [3:0] OP_DP_HI = 4'b1001;
  localparam logic [3:0] OP_BEQ   = 4'b1011;
  localparam logic [3:0] OP_BNE   = 4'b1100;
  localparam logic [3:0] OP_J     = 4'b1101;

  localparam logic [1:0] ALU_FUNCT = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_ADD   = 2'b10;

  localparam logic [1:0] PC_INC    = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;

  typedef enum logic [2:0] {
    C_MEM, C_DP, C_BEQ, C_BNE, C_J, C_TRAP
  } op_class_t;

  // Reserved opcodes fall into data-processing unless trapping is built in.
  function automatic op_class_t classify(input logic [3:0] op);
    op_class_t cls;
    if (op == OP_LW || op == OP_SW)             cls = C_MEM;
    else if (op >= OP_DP_LO && op <= OP_DP_HI)  cls = C_DP;
    else if (op == OP_BEQ)                      cls = C_BEQ;
    else if (op == OP_BNE)                      cls = C_BNE;
    else if (op == OP_J)                        cls = C_J;
    else
`ifdef MCU_TRAP_EN
      cls = C_TRAP;
`else
      cls = C_DP;
`endif
    return cls;
  endfunction

endpackage

// File: rtl/multi_cycle_controller_if.sv
// Shared single-port memory handshake: mem_req is held until the cycle mem_ready is seen high;
// the request completes on the clock edge where mem_req && mem_ready, and mem_ready without mem_req is ignored.
interface multi_cycle_controller_if;
  logic mem_req;
  logic mem_we;
  logic iord;
  logic mem_ready;

  modport master (output mem_req, output mem_we, output iord, input mem_ready);
  modport slave  (input mem_req, input mem_we, input iord, output mem_ready);
endinterface

// File: rtl/multi_cycle_controller_mem_wait_timer.sv
// Bounded-wait counter for memory requests; expired flags the last permitted wait cycle.
module mem_wait_timer #(
  parameter int WAIT_CYCLES = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic expired
);
  localparam int CW = $clog2(WAIT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (count_en && count != LAST) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == LAST);
endmodule

// File: rtl/multi_cycle_controller.sv
// Multi-cycle sequencer: FETCH/DECODE/EXEC/MEM/WB with a bounded memory wait into FAULT.
// Optional define MCU_TRAP_EN sends reserved opcodes to a sticky TRAP state.
module multi_cycle_controller
  import risc_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = 15
) (
  input  logic                             clk,
  input  logic                             rst,
  multi_cycle_controller_if.master         bus,
  input  logic [3:0]                       opcode,
  input  logic                             zero,
  output logic                             ir_write,
  output logic                             pc_write,
  output logic [1:0]                       pc_src,
  output logic                             reg_dst,
  output logic                             alu_src,
  output logic                             mem_to_reg,
  output logic                             reg_write,
  output logic [1:0]                       alu_op,
  output logic [2:0]                       state,
  output logic                             fault
);
  state_t    state_q, state_d;
  op_class_t op_cls;
  logic      waiting, expired;

  assign op_cls  = classify(opcode);
  assign waiting = bus.mem_req && !bus.mem_ready;

  // Any non-waiting cycle clears the timer, which covers entry to FETCH and MEM.
  mem_wait_timer #(.WAIT_CYCLES(WAIT_CYCLES)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (!waiting),
    .count_en (waiting),
    .expired  (expired)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Every output is forced low while rst is high, so nothing commits in the reset cycle.
  always_comb begin
    state_d     = state_q;
    bus.mem_req = 1'b0;
    bus.mem_we  = 1'b0;
    bus.iord    = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_src      = PC_INC;
    reg_dst     = 1'b0;
    alu_src     = 1'b0;
    mem_to_reg  = 1'b0;
    reg_write   = 1'b0;
    alu_op      = ALU_FUNCT;
    fault       = 1'b0;
    state       = rst ? 3'd0 : state_q;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          bus.mem_req = 1'b1;
          if (bus.mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            pc_src   = PC_INC;
            state_d  = S_DECODE;
          end else if (expired) begin
            state_d = S_FAULT;
          end
        end
        S_DECODE: state_d = S_EXEC;
        S_EXEC: begin
          case (op_cls)
            C_MEM: begin
              alu_src = 1'b1;
              alu_op  = ALU_ADD;
              state_d = S_MEM;
            end
            C_BEQ: begin
              alu_op   = ALU_SUB;
              pc_write = zero;
              pc_src   = PC_BRANCH;
              state_d  = S_FETCH;
            end
            C_BNE: begin
              alu_op   = ALU_SUB;
              pc_write = !zero;
              pc_src   = PC_BRANCH;
              state_d  = S_FETCH;
            end
            C_J: begin
              pc_write = 1'b1;
              pc_src   = PC_JUMP;
              state_d  = S_FETCH;
            end
            C_TRAP:  state_d = S_TRAP;
            default: state_d = S_WB;
          endcase
        end
        S_MEM: begin
          bus.mem_req = 1'b1;
          bus.iord    = 1'b1;
          bus.mem_we  = (opcode == OP_SW);
          if (bus.mem_ready) begin
            state_d = (opcode == OP_LW) ? S_WB : S_FETCH;
          end else if (expired) begin
            state_d = S_FAULT;
          end
        end
        S_WB: begin
          reg_write  = 1'b1;
          reg_dst    = (opcode != OP_LW);
          mem_to_reg = (opcode == OP_LW);
          state_d    = S_FETCH;
        end
        S_FAULT, S_TRAP: fault = 1'b1;
        default: state_d = S_FETCH;
      endcase
    end
  end
endmodule

// File: tb/tb_multi_cycle_controller.sv
// Bench for multi_cycle_controller: per-cycle expected traces built from instruction-level rules.
module tb_multi_cycle_controller;
  localparam int W = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] opcode = 4'd0;
  logic       zero = 1'b0;
  logic       ir_write, pc_write, reg_dst, alu_src, mem_to_reg, reg_write, fault;
  logic [1:0] pc_src, alu_op;
  logic [2:0] state;

  multi_cycle_controller_if bus();

  multi_cycle_controller #(.WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .bus(bus), .opcode(opcode), .zero(zero),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .reg_dst(reg_dst), .alu_src(alu_src), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .alu_op(alu_op), .state(state), .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] state;
    logic       fault;
    logic       mem_req, mem_we, iord, ir_write, pc_write;
    logic [1:0] pc_src;
    logic       reg_dst, alu_src, mem_to_reg, reg_write;
    logic [1:0] alu_op;
  } out_t;

  typedef struct packed {
    logic       rdy;
    logic [3:0] op;
    logic       z;
  } stim_t;

  typedef struct {
    logic [3:0] op;
    logic       z;
    int         fw;
    int         mw;
    int         lat;
  } vec_t;

  typedef enum int {K_LD, K_ST, K_DP, K_BEQ, K_BNE, K_J, K_TRAP} kind_t;

  localparam int OW = $bits(out_t);
  logic [OW-1:0] exp_q[$];
  stim_t         stim_q[$];
  int            n_vec = 0;
  int            n_err = 0;

  function automatic out_t blank(input logic [2:0] st);
    out_t o;
    o = '0;
    o.state = st;
    return o;
  endfunction

  function automatic out_t sample();
    out_t a;
    a.state = state;           a.fault = fault;
    a.mem_req = bus.mem_req;   a.mem_we = bus.mem_we;   a.iord = bus.iord;
    a.ir_write = ir_write;     a.pc_write = pc_write;   a.pc_src = pc_src;
    a.reg_dst = reg_dst;       a.alu_src = alu_src;     a.mem_to_reg = mem_to_reg;
    a.reg_write = reg_write;   a.alu_op = alu_op;
    return a;
  endfunction

  function automatic kind_t kind(input logic [3:0] op);
    case (op)
      4'd0:  return K_LD;
      4'd1:  return K_ST;
      4'd11: return K_BEQ;
      4'd12: return K_BNE;
      4'd13: return K_J;
`ifdef MCU_TRAP_EN
      4'd10, 4'd14, 4'd15: return K_TRAP;
`endif
      default: return K_DP;
    endcase
  endfunction

  task automatic check(input string name, input int cyc, input out_t e, input out_t a);
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, a, e);
    end
  endtask

  task automatic push(input out_t o, input logic rdy, input logic [3:0] op, input logic z);
    stim_t s;
    s.rdy = rdy; s.op = op; s.z = z;
    exp_q.push_back(o);
    stim_q.push_back(s);
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Reference trace for one instruction: fw/mw are wait cycles before mem_ready in FETCH/MEM.
  task automatic gen_instr(input logic [3:0] op, input logic z, input int fw, input int mw);
    kind_t k;
    out_t  o;
    k = kind(op);
    for (int i = 0; i < fw && i < W; i++) begin
      o = blank(3'd0); o.mem_req = 1'b1;
      push(o, 1'b0, 4'($urandom_range(0, 15)), z);
    end
    if (fw >= W) begin
      repeat (3) begin o = blank(3'd5); o.fault = 1'b1; push(o, rbit(), op, z); end
      return;
    end
    o = blank(3'd0); o.mem_req = 1'b1; o.ir_write = 1'b1; o.pc_write = 1'b1;
    push(o, 1'b1, 4'($urandom_range(0, 15)), z);
    push(blank(3'd1), rbit(), op, z);
    o = blank(3'd2);
    case (k)
      K_LD, K_ST: begin o.alu_src = 1'b1; o.alu_op = 2'b10; end
      K_BEQ:      begin o.alu_op = 2'b01; o.pc_write = z;  o.pc_src = 2'd1; end
      K_BNE:      begin o.alu_op = 2'b01; o.pc_write = !z; o.pc_src = 2'd1; end
      K_J:        begin o.pc_write = 1'b1; o.pc_src = 2'd2; end
      default:    ;
    endcase
    push(o, rbit(), op, z);
    if (k == K_TRAP) begin
      repeat (3) begin o = blank(3'd6); o.fault = 1'b1; push(o, rbit(), op, z); end
      return;
    end
    if (k == K_LD || k == K_ST) begin
      o = blank(3'd3); o.mem_req = 1'b1; o.iord = 1'b1; o.mem_we = (k == K_ST);
      for (int i = 0; i < mw && i < W; i++) push(o, 1'b0, op, z);
      if (mw >= W) begin
        repeat (3) begin o = blank(3'd5); o.fault = 1'b1; push(o, rbit(), op, z); end
        return;
      end
      push(o, 1'b1, op, z);
    end
    if (k == K_LD || k == K_DP) begin
      o = blank(3'd4); o.reg_write = 1'b1; o.reg_dst = (k == K_DP); o.mem_to_reg = (k == K_LD);
      push(o, rbit(), op, z);
    end
  endtask

  task automatic trim(input int n);
    while (exp_q.size() > n) begin
      exp_q.delete(exp_q.size() - 1);
      stim_q.delete(stim_q.size() - 1);
    end
  endtask

  // Applies the queued trace; lat > 0 also checks cycles until the DUT is back in FETCH.
  task automatic run_queue(input string name, input int lat);
    int         n, measured;
    logic [2:0] prev;
    stim_t      s;
    out_t       e, a;
    n = stim_q.size();
    measured = -1;
    prev = 3'd0;
    for (int i = 0; i < n; i++) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      bus.mem_ready = s.rdy; opcode = s.op; zero = s.z;
      @(negedge clk);
      a = sample();
      check(name, i, e, a);
      if (i > 0 && prev != 3'd0 && a.state == 3'd0 && measured < 0) measured = i;
      prev = a.state;
      @(posedge clk); #1;
    end
    if (lat > 0) begin
      if (measured < 0 && prev != 3'd0 && state == 3'd0) measured = n;
      n_vec++;
      if (measured != lat) begin
        n_err++;
        $display("FAIL %s latency: got %0d expected %0d", name, measured, lat);
      end
    end
  endtask

  task automatic reset_cycle(input string name);
    rst = 1'b1; bus.mem_ready = 1'b1; opcode = 4'($urandom_range(0, 15));
    @(negedge clk);
    check(name, 0, blank(3'd0), sample());
    @(posedge clk); #1;
    rst = 1'b0; bus.mem_ready = 1'b0;
  endtask

  vec_t vecs[10];
`ifdef MCU_TRAP_EN
  localparam int TRAP_LAT = 0;
`else
  localparam int TRAP_LAT = 4;
`endif

  initial begin
    vecs[0] = '{4'b0010, 1'b0, 0, 0, 4};
    vecs[1] = '{4'b0000, 1'b0, 0, 3, 8};
    vecs[2] = '{4'b1011, 1'b1, 0, 0, 3};
    vecs[3] = '{4'b1100, 1'b1, 0, 0, 3};
    vecs[4] = '{4'b0001, 1'b0, 0, 0, 4};
    vecs[5] = '{4'b1101, 1'b0, 3, 0, 6};
    vecs[6] = '{4'b1001, 1'b1, 2, 0, 6};
    vecs[7] = '{4'b0001, 1'b1, 1, 2, 7};
    vecs[8] = '{4'b0000, 1'b0, 3, 3, 11};
    vecs[9] = '{4'b1011, 1'b0, 0, 0, 3};

    bus.mem_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("reset_hold", 0, blank(3'd0), sample());
    @(posedge clk); #1;
    rst = 1'b0;

    foreach (vecs[i]) begin
      gen_instr(vecs[i].op, vecs[i].z, vecs[i].fw, vecs[i].mw);
      run_queue($sformatf("vec%0d", i), vecs[i].lat);
    end

    for (int i = 0; i < 25; i++) begin
      logic [3:0] op;
      int fw, mw;
      op = 4'($urandom_range(0, 15));
`ifdef MCU_TRAP_EN
      if (op == 4'd10 || op >= 4'd14) op = 4'b0011;
`endif
      fw = $urandom_range(0, W - 1);
      mw = $urandom_range(0, W - 1);
      gen_instr(op, rbit(), fw, mw);
      run_queue($sformatf("rand%0d", i), 0);
    end

    gen_instr(4'b0010, 1'b0, W + 2, 0);
    run_queue("fetch_timeout", 0);
    reset_cycle("fault_reset");
    gen_instr(4'b0010, 1'b0, 0, 0);
    run_queue("after_fault", 4);

    gen_instr(4'b0001, 1'b0, 0, W + 1);
    run_queue("mem_timeout", 0);
    reset_cycle("mem_fault_reset");

    gen_instr(4'b1111, 1'b0, 0, 0);
    run_queue("op1111", TRAP_LAT);
    reset_cycle("op1111_reset");

    gen_instr(4'b0001, 1'b0, 0, 0);
    trim(3);
    run_queue("sw_to_mem", 0);
    reset_cycle("sw_rst_in_mem");
    gen_instr(4'b0010, 1'b0, 0, 0);
    run_queue("after_sw_rst", 4);

    gen_instr(4'b0010, 1'b0, 3, 0);
    trim(3);
    run_queue("wait_before_rst", 0);
    reset_cycle("rst_mid_fetch");
    gen_instr(4'b0010, 1'b0, 3, 0);
    run_queue("timer_cleared", 7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule
